// File: rtl/fnd_scan_controller.sv
// Multiplexed 7-segment scan controller with frame snapshots, ghost blanking, blink and range check.
// Optional build macro FND_LZB_EN enables leading-zero blanking of the hour10 digit.
module fnd_scan_controller #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int NUM_DIGITS = 4,
  parameter int BLINK_HZ   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [23:0]           i_time,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  output logic [NUM_DIGITS-1:0] fnd_com,
  output logic [7:0]            fnd_data
);

  localparam int DIV         = CLK_FREQ / SCAN_HZ;
  localparam int PW          = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW          = $clog2(NUM_DIGITS);
  localparam int BLINK_TICKS = SCAN_HZ / (2 * BLINK_HZ);
  localparam int BW          = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  typedef enum logic [1:0] {
    FLD_MSEC = 2'd0,
    FLD_SEC  = 2'd1,
    FLD_MIN  = 2'd2,
    FLD_HOUR = 2'd3
  } field_e;

  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic [23:0]           r_snap;
  logic                  r_page;
  logic [NUM_DIGITS-1:0] r_bmask;
  logic [BW-1:0]         r_blinkCnt;
  logic                  r_phase;
  logic                  r_comPending;
  logic [NUM_DIGITS-1:0] r_com;
  logic [7:0]            r_data;

  logic                  w_tick;
  logic                  w_wrap;
  logic                  w_blinkToggle;
  logic [IW-1:0]         w_idxNext;
  logic [23:0]           w_snapNext;
  logic                  w_pageNext;
  logic [NUM_DIGITS-1:0] w_bmaskNext;
  logic                  w_phaseNext;
  logic [2:0]            w_sel;
  field_e                w_fld;
  logic [6:0]            w_field;
  logic [6:0]            w_max;
  logic                  w_oor;
  logic [3:0]            w_tens;
  logic [3:0]            w_ones;
  logic                  w_dpDigit;
  logic [7:0]            w_pat;

  function automatic logic [7:0] segCode(input logic [3:0] d);
    case (d)
      4'd0:    segCode = 8'hC0;
      4'd1:    segCode = 8'hF9;
      4'd2:    segCode = 8'hA4;
      4'd3:    segCode = 8'hB0;
      4'd4:    segCode = 8'h99;
      4'd5:    segCode = 8'h92;
      4'd6:    segCode = 8'h82;
      4'd7:    segCode = 8'hF8;
      4'd8:    segCode = 8'h80;
      4'd9:    segCode = 8'h90;
      default: segCode = 8'hFF;
    endcase
  endfunction

  // Everything that changes on a tick is looked at through its post-tick value, so the
  // pattern registered on the tick already reflects the new idx, snapshot, page and phase.
  assign w_tick        = (r_presc == PW'(DIV - 1));
  assign w_wrap        = w_tick && (r_idx == IW'(NUM_DIGITS - 1));
  assign w_blinkToggle = w_tick && (r_blinkCnt == BW'(BLINK_TICKS - 1));
  assign w_idxNext     = w_wrap ? '0 : r_idx + IW'(1);
  assign w_snapNext    = w_wrap ? i_time : r_snap;
  assign w_pageNext    = w_wrap ? mode : r_page;
  assign w_bmaskNext   = w_wrap ? blink_mask : r_bmask;
  assign w_phaseNext   = w_blinkToggle ? ~r_phase : r_phase;

  always_comb begin
    w_sel = (NUM_DIGITS == 8) ? 3'(w_idxNext) : {w_pageNext, w_idxNext[1:0]};
    w_fld = field_e'(w_sel[2:1]);
    w_field = 7'd0;
    w_max   = 7'd0;
    case (w_fld)
      FLD_MSEC: begin w_field = w_snapNext[6:0];          w_max = 7'd99; end
      FLD_SEC:  begin w_field = 7'(w_snapNext[12:7]);     w_max = 7'd59; end
      FLD_MIN:  begin w_field = 7'(w_snapNext[18:13]);    w_max = 7'd59; end
      FLD_HOUR: begin w_field = 7'(w_snapNext[23:19]);    w_max = 7'd23; end
      default:  begin w_field = 7'd0;                     w_max = 7'd0;  end
    endcase
    w_oor  = (w_field > w_max);
    w_tens = 4'(w_field / 7'd10);
    w_ones = 4'(w_field % 7'd10);
    w_dpDigit = (w_idxNext == IW'(2)) || ((NUM_DIGITS == 8) && (w_idxNext == IW'(4)));

    w_pat = segCode(w_sel[0] ? w_tens : w_ones);
    if (w_oor) w_pat = 8'hBF;
`ifdef FND_LZB_EN
    if ((w_sel == 3'd7) && !w_oor && (w_field < 7'd10)) w_pat = 8'hFF;
`endif
    if (!w_oor && w_dpDigit && (w_snapNext[6:0] < 7'd50)) w_pat[7] = 1'b0;
    if (!w_phaseNext && w_bmaskNext[w_idxNext]) w_pat = 8'hFF;
  end

  // Each tick blanks the commons for one cycle while the new pattern settles, then enables the new digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_snap       <= '0;
      r_page       <= 1'b0;
      r_bmask      <= '0;
      r_blinkCnt   <= '0;
      r_phase      <= 1'b1;
      r_comPending <= 1'b0;
      r_com        <= '1;
      r_data       <= 8'hFF;
    end else begin
      r_presc      <= w_tick ? '0 : r_presc + PW'(1);
      r_comPending <= w_tick;
      if (w_tick) begin
        r_idx      <= w_idxNext;
        r_snap     <= w_snapNext;
        r_page     <= w_pageNext;
        r_bmask    <= w_bmaskNext;
        r_blinkCnt <= w_blinkToggle ? '0 : r_blinkCnt + BW'(1);
        r_phase    <= w_phaseNext;
        r_data     <= w_pat;
        r_com      <= '1;
      end else if (r_comPending) begin
        r_com <= ~(NUM_DIGITS'(1) << r_idx);
      end
    end
  end

  assign fnd_com  = r_com;
  assign fnd_data = r_data;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed testbench for fnd_scan_controller: a 4-digit and an 8-digit instance share clock and reset.
// Expected hour10 value follows FND_LZB_EN.
module tb_fnd_scan_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mode4 = 1'b0;
  logic        mode8 = 1'b0;
  logic [23:0] time4 = '0;
  logic [23:0] time8 = '0;
  logic [3:0]  bmask4 = '0;
  logic [7:0]  bmask8 = '0;
  logic [3:0]  com4;
  logic [7:0]  data4;
  logic [7:0]  com8;
  logic [7:0]  data8;

  int checks = 0;
  int passes = 0;

`ifdef FND_LZB_EN
  localparam logic [7:0] EXP_H10 = 8'hFF;
`else
  localparam logic [7:0] EXP_H10 = 8'hC0;
`endif

  fnd_scan_controller #(.CLK_FREQ(1000), .SCAN_HZ(100), .NUM_DIGITS(4), .BLINK_HZ(10)) u_dut4 (
    .clk(clk), .rst(rst), .mode(mode4), .i_time(time4), .blink_mask(bmask4),
    .fnd_com(com4), .fnd_data(data4)
  );

  fnd_scan_controller #(.CLK_FREQ(1000), .SCAN_HZ(100), .NUM_DIGITS(8), .BLINK_HZ(10)) u_dut8 (
    .clk(clk), .rst(rst), .mode(mode8), .i_time(time8), .blink_mask(bmask8),
    .fnd_com(com8), .fnd_data(data8)
  );

  always #5 clk = ~clk;

  task automatic hold_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) until the given digit is enabled and returns the segments shown on it.
  task automatic cap4(input int idx, output logic [7:0] d, output bit ok);
    ok = 1'b0;
    d  = 8'hxx;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (com4 == ~(4'b0001 << idx)) begin
        d  = data4;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic cap8(input int idx, output logic [7:0] d, output bit ok);
    ok = 1'b0;
    d  = 8'hxx;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (com8 == ~(8'b0000_0001 << idx)) begin
        d  = data8;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (com4 !== 4'hF) $display("[TB] FAIL reset_com4: got %h expected F", com4); else passes++;
    checks++; if (data4 !== 8'hFF) $display("[TB] FAIL reset_data4: got %h expected FF", data4); else passes++;
    checks++; if (com8 !== 8'hFF) $display("[TB] FAIL reset_com8: got %h expected FF", com8); else passes++;
    checks++; if (data8 !== 8'hFF) $display("[TB] FAIL reset_data8: got %h expected FF", data8); else passes++;
  endtask

  task automatic test_scan();
    logic [3:0] e4;
    time4 = {5'd13, 6'd45, 6'd7, 7'd31};
    mode4 = 1'b0;
    bmask4 = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      e4 = (k < 10 || k % 10 == 0) ? 4'hF : ~(4'b0001 << ((k / 10) % 4));
      checks++;
      if (com4 !== e4) $display("[TB] FAIL scan_com k=%0d: got %h expected %h", k, com4, e4);
      else passes++;
      // Before the first wrap the snapshot is still zero; the wrap at k=40 loads msec=31.
      if (k == 10) begin
        checks++; if (data4 !== 8'hC0) $display("[TB] FAIL scan_data_idx1: got %h expected C0", data4); else passes++;
      end
      if (k == 20) begin
        checks++; if (data4 !== 8'h40) $display("[TB] FAIL scan_data_idx2: got %h expected 40", data4); else passes++;
      end
      if (k == 40) begin
        checks++; if (data4 !== 8'hF9) $display("[TB] FAIL scan_data_wrap: got %h expected F9", data4); else passes++;
      end
    end
  endtask

  task automatic test_blink();
    logic [7:0] codes [4];
    logic [7:0] e;
    int n;
    int idx;
    codes[0] = 8'h92; codes[1] = 8'hF8; codes[2] = 8'hF8; codes[3] = 8'hC0;
    time4  = {5'd13, 6'd45, 6'd7, 7'd75};
    mode4  = 1'b0;
    bmask4 = 4'b1100;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 240; k++) begin
      @(posedge clk);
      #1;
      if (k % 10 == 0 && k >= 40) begin
        n   = k / 10;
        idx = n % 4;
        e   = (idx >= 2 && ((n / 5) % 2 == 1)) ? 8'hFF : codes[idx];
        checks++;
        if (data4 !== e) $display("[TB] FAIL blink tick=%0d idx=%0d: got %h expected %h", n, idx, data4, e);
        else passes++;
      end
    end
    bmask4 = '0;
  endtask

  task automatic test_page_change();
    logic [7:0] d;
    bit ok;
    time4  = {5'd13, 6'd45, 6'd7, 7'd30};
    mode4  = 1'b0;
    bmask4 = '0;
    hold_reset();
    repeat (60) @(posedge clk);
    cap4(2, d, ok);
    checks++; if (!ok || d !== 8'h78) $display("[TB] FAIL page0_idx2: got %h expected 78", d); else passes++;
    mode4 = 1'b1;
    cap4(3, d, ok);
    checks++; if (!ok || d !== 8'hC0) $display("[TB] FAIL page_midframe_idx3: got %h expected C0", d); else passes++;
    cap4(0, d, ok);
    checks++; if (!ok || d !== 8'h92) $display("[TB] FAIL page1_idx0: got %h expected 92", d); else passes++;
    cap4(1, d, ok);
    checks++; if (!ok || d !== 8'h99) $display("[TB] FAIL page1_idx1: got %h expected 99", d); else passes++;
    cap4(2, d, ok);
    checks++; if (!ok || d !== 8'h30) $display("[TB] FAIL page1_idx2_dp: got %h expected 30", d); else passes++;
    cap4(3, d, ok);
    checks++; if (!ok || d !== 8'hF9) $display("[TB] FAIL page1_idx3: got %h expected F9", d); else passes++;
    time4 = {5'd13, 6'd45, 6'd7, 7'd75};
    repeat (100) @(posedge clk);
    cap4(2, d, ok);
    checks++; if (!ok || d !== 8'hB0) $display("[TB] FAIL page1_idx2_nodp: got %h expected B0", d); else passes++;
  endtask

  task automatic test_eight_digit();
    logic [7:0] exp30 [8];
    logic [7:0] d;
    bit ok;
    exp30[0] = 8'hC0; exp30[1] = 8'hB0; exp30[2] = 8'h78; exp30[3] = 8'hC0;
    exp30[4] = 8'h12; exp30[5] = 8'h99; exp30[6] = 8'hB0; exp30[7] = 8'hF9;
    time8 = {5'd13, 6'd45, 6'd7, 7'd30};
    repeat (200) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      cap8(i, d, ok);
      checks++;
      if (!ok || d !== exp30[i]) $display("[TB] FAIL eight_digit idx=%0d: got %h expected %h", i, d, exp30[i]);
      else passes++;
    end
    time8 = {5'd13, 6'd45, 6'd7, 7'd75};
    repeat (200) @(posedge clk);
    cap8(2, d, ok);
    checks++; if (!ok || d !== 8'hF8) $display("[TB] FAIL eight_nodp_idx2: got %h expected F8", d); else passes++;
    cap8(4, d, ok);
    checks++; if (!ok || d !== 8'h92) $display("[TB] FAIL eight_nodp_idx4: got %h expected 92", d); else passes++;
  endtask

  task automatic test_out_of_range();
    logic [7:0] expv [8];
    logic [7:0] d;
    bit ok;
    expv[0] = 8'h92; expv[1] = 8'hF8; expv[2] = 8'hBF; expv[3] = 8'hBF;
    expv[4] = 8'h92; expv[5] = 8'h99; expv[6] = 8'hBF; expv[7] = 8'hBF;
    time8 = {5'd25, 6'd45, 6'd60, 7'd75};
    repeat (200) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      cap8(i, d, ok);
      checks++;
      if (!ok || d !== expv[i]) $display("[TB] FAIL out_of_range idx=%0d: got %h expected %h", i, d, expv[i]);
      else passes++;
    end
  endtask

  task automatic test_lzb();
    logic [7:0] d;
    bit ok;
    time8 = {5'd7, 6'd45, 6'd7, 7'd75};
    repeat (200) @(posedge clk);
    cap8(6, d, ok);
    checks++; if (!ok || d !== 8'hF8) $display("[TB] FAIL lzb_hour1: got %h expected F8", d); else passes++;
    cap8(7, d, ok);
    checks++; if (!ok || d !== EXP_H10) $display("[TB] FAIL lzb_hour10: got %h expected %h", d, EXP_H10); else passes++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    bit ok;
    cap4(1, d, ok);
    checks++; if (!ok || com4 !== 4'hD) $display("[TB] FAIL midreset_pre_com: got %h expected D", com4); else passes++;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (com4 !== 4'hF) $display("[TB] FAIL midreset_com4: got %h expected F", com4); else passes++;
    checks++; if (data4 !== 8'hFF) $display("[TB] FAIL midreset_data4: got %h expected FF", data4); else passes++;
    checks++; if (com8 !== 8'hFF) $display("[TB] FAIL midreset_com8: got %h expected FF", com8); else passes++;
    checks++; if (data8 !== 8'hFF) $display("[TB] FAIL midreset_data8: got %h expected FF", data8); else passes++;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk);
      #1;
      if (k == 9) begin
        checks++; if (com4 !== 4'hF) $display("[TB] FAIL restart_dark: got %h expected F", com4); else passes++;
      end
      if (k == 10) begin
        checks++; if (data4 !== 8'hC0) $display("[TB] FAIL restart_data: got %h expected C0", data4); else passes++;
      end
      if (k == 11) begin
        checks++; if (com4 !== 4'hD) $display("[TB] FAIL restart_com: got %h expected D", com4); else passes++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blink();
    test_page_change();
    test_eight_digit();
    test_out_of_range();
    test_lzb();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
